// File: rtl/uart_bridge_pkg.sv
// Shared command codes, FSM state encoding and the FSM-to-sender byte request
// used by the UART/SPRAM bridge.
package uart_bridge_pkg;

  localparam logic [7:0] CMD_WR  = 8'h57;
  localparam logic [7:0] CMD_RD  = 8'h52;
  localparam logic [7:0] CMD_CLR = 8'h43;
  localparam logic [7:0] ACK     = 8'h06;
  localparam logic [7:0] NAK     = 8'h15;

  typedef enum logic [3:0] {
    IDLE, A_HI, A_LO, LEN, D_HI, D_LO, WRITE,
    RD_ADDR, RD_WAIT, TX_HI, TX_LO, REPLY
  } state_e;

  typedef struct packed {
    logic       vld;
    logic [7:0] data;
  } tx_req_t;

  // States where the host is expected to keep bytes coming.
  function automatic logic is_frame_state(state_e s);
    return s inside {A_HI, A_LO, LEN, D_HI, D_LO};
  endfunction

  // States where an incoming byte cannot be consumed.
  function automatic logic is_overrun_state(state_e s);
    return s inside {RD_ADDR, RD_WAIT, TX_HI, TX_LO, REPLY};
  endfunction

endpackage

// File: rtl/uart_spram_bridge_if.sv
// Bridge-side bundle: uart rx/tx handshake, SPRAM port and status flags.
interface uart_spram_bridge_if #(
  parameter int ADDR_W = 14
);
  logic              rx_valid;
  logic [7:0]        rx_data;
  logic              tx_busy;
  logic              tx_send;
  logic [7:0]        tx_data;
  logic [ADDR_W-1:0] ram_addr;
  logic [15:0]       ram_wdata;
  logic              ram_wren;
  logic [15:0]       ram_rdata;
  logic              busy;
  logic              err;

  modport slave (
    input  rx_valid, rx_data, tx_busy, ram_rdata,
    output tx_send, tx_data, ram_addr, ram_wdata, ram_wren, busy, err
  );

  modport master (
    output rx_valid, rx_data, tx_busy, ram_rdata,
    input  tx_send, tx_data, ram_addr, ram_wdata, ram_wren, busy, err
  );
endinterface

// File: rtl/uart_spram_bridge_tx_byte_sender.sv
// Owns the uart tx handshake; a one-byte holding buffer lets the FSM hand off a
// byte while the transmitter is still busy with the previous one.
module tx_byte_sender
  import uart_bridge_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  tx_req_t    req,
  output logic       ack,
  input  logic       tx_busy,
  output logic       tx_send,
  output logic [7:0] tx_data
);
  logic       send_q, send_d, full_q, full_d;
  logic [7:0] data_q, data_d, buf_q, buf_d;

  // A request is taken whenever the buffer is free: sent directly or parked.
  assign ack = req.vld && !full_q;

  always_comb begin
    send_d = !tx_busy && !send_q && (full_q || req.vld);
    data_d = data_q;
    buf_d  = buf_q;
    full_d = full_q;
    if (send_d) data_d = full_q ? buf_q : req.data;
    if (full_q) begin
      if (send_d) full_d = 1'b0;
    end else if (req.vld && !send_d) begin
      full_d = 1'b1;
      buf_d  = req.data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      send_q <= 1'b0;
      full_q <= 1'b0;
      data_q <= '0;
      buf_q  <= '0;
    end else begin
      send_q <= send_d;
      full_q <= full_d;
      data_q <= data_d;
      buf_q  <= buf_d;
    end
  end

  assign tx_send = send_q;
  assign tx_data = data_q;

endmodule

// File: rtl/uart_spram_bridge.sv
// Host-driven SPRAM load/dump over a byte link: W/R bursts of 16-bit words,
// C clears the sticky error, anything else is NAKed.
module uart_spram_bridge
  import uart_bridge_pkg::*;
#(
  parameter int ADDR_W      = 14,
  parameter int RD_LAT      = 1,
  parameter int TIMEOUT_CYC = 400000
) (
  input logic                clk,
  input logic                rst,
  uart_spram_bridge_if.slave bus
);
  localparam int            TW       = $clog2(TIMEOUT_CYC + 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYC - 1);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [7:0]        len_q, len_d, cnt_q, cnt_d, hi_q, hi_d;
  logic [15:0]       rd_word_q, rd_word_d, wdata_q, wdata_d;
  logic [TW-1:0]     tmo_q, tmo_d;
  logic [RD_LAT-1:0] vld_pipe_q, vld_pipe_d;
  logic              wren_q, wren_d, err_q, err_d, is_wr_q, is_wr_d;
  tx_req_t           tx_req;
  logic              tx_ack, rx, last;

  assign rx   = bus.rx_valid;
  assign last = (cnt_q == len_q);

  tx_byte_sender u_tx (
    .clk     (clk),
    .rst     (rst),
    .req     (tx_req),
    .ack     (tx_ack),
    .tx_busy (bus.tx_busy),
    .tx_send (bus.tx_send),
    .tx_data (bus.tx_data)
  );

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    len_d      = len_q;
    cnt_d      = cnt_q;
    hi_d       = hi_q;
    rd_word_d  = rd_word_q;
    wdata_d    = wdata_q;
    wren_d     = 1'b0;
    err_d      = err_q;
    is_wr_d    = is_wr_q;
    tmo_d      = '0;
    tx_req     = '0;
    // Read-latency tracker: a 1 enters when the address is presented.
    vld_pipe_d = RD_LAT'({vld_pipe_q, state_q == RD_ADDR});

    if (is_frame_state(state_q) && !rx) tmo_d = tmo_q + TW'(1);

    // A byte landing on the expiry cycle wins over the timeout.
    if (is_frame_state(state_q) && !rx && tmo_q == TMO_LAST) begin
      tx_req  = '{vld: 1'b1, data: NAK};
      err_d   = 1'b1;
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: if (rx) begin
          case (bus.rx_data)
            CMD_WR:  begin is_wr_d = 1'b1; state_d = A_HI; end
            CMD_RD:  begin is_wr_d = 1'b0; state_d = A_HI; end
            CMD_CLR: begin err_d = 1'b0; state_d = REPLY; end
            default: begin err_d = 1'b1; tx_req = '{vld: 1'b1, data: NAK}; end
          endcase
        end
        A_HI: if (rx) begin hi_d = bus.rx_data; state_d = A_LO; end
        A_LO: if (rx) begin addr_d = ADDR_W'({hi_q, bus.rx_data}); state_d = LEN; end
        LEN: if (rx) begin
          len_d   = bus.rx_data;
          cnt_d   = '0;
          state_d = is_wr_q ? D_HI : RD_ADDR;
        end
        D_HI: if (rx) begin hi_d = bus.rx_data; state_d = D_LO; end
        D_LO: if (rx) begin
          wren_d  = 1'b1;
          wdata_d = {hi_q, bus.rx_data};
          state_d = WRITE;
        end
        WRITE: begin
          addr_d = addr_q + ADDR_W'(1);
          if (last) begin
            tx_req  = '{vld: 1'b1, data: ACK};
            state_d = tx_ack ? IDLE : REPLY;
          end else begin
            cnt_d   = cnt_q + 8'd1;
            state_d = D_HI;
          end
        end
        RD_ADDR: state_d = RD_WAIT;
        RD_WAIT: if (vld_pipe_q[RD_LAT-1]) begin
          rd_word_d = bus.ram_rdata;
          state_d   = TX_HI;
        end
        TX_HI: begin
          tx_req = '{vld: 1'b1, data: rd_word_q[15:8]};
          if (tx_ack) state_d = TX_LO;
        end
        TX_LO: begin
          tx_req = '{vld: 1'b1, data: rd_word_q[7:0]};
          if (tx_ack) begin
            addr_d = addr_q + ADDR_W'(1);
            if (last) state_d = IDLE;
            else begin
              cnt_d   = cnt_q + 8'd1;
              state_d = RD_ADDR;
            end
          end
        end
        REPLY: begin
          tx_req = '{vld: 1'b1, data: ACK};
          if (tx_ack) state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end

    if (rx && is_overrun_state(state_q)) err_d = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      addr_q     <= '0;
      len_q      <= '0;
      cnt_q      <= '0;
      hi_q       <= '0;
      rd_word_q  <= '0;
      wdata_q    <= '0;
      wren_q     <= 1'b0;
      err_q      <= 1'b0;
      is_wr_q    <= 1'b0;
      tmo_q      <= '0;
      vld_pipe_q <= '0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      len_q      <= len_d;
      cnt_q      <= cnt_d;
      hi_q       <= hi_d;
      rd_word_q  <= rd_word_d;
      wdata_q    <= wdata_d;
      wren_q     <= wren_d;
      err_q      <= err_d;
      is_wr_q    <= is_wr_d;
      tmo_q      <= tmo_d;
      vld_pipe_q <= vld_pipe_d;
    end
  end

  assign bus.ram_addr  = addr_q;
  assign bus.ram_wdata = wdata_q;
  assign bus.ram_wren  = wren_q;
  assign bus.busy      = (state_q != IDLE);
  assign bus.err       = err_q;

endmodule

// File: tb/tb_uart_spram_bridge.sv
// Directed frames against a host/uart/SPRAM model with queued expectations.
module tb_uart_spram_bridge;
  localparam int ADW      = 14;
  localparam int TMO      = 40;
  localparam int BUSY_LEN = 6;
  localparam int M        = 1 << ADW;

  typedef struct { int addr; logic [15:0] data; int cyc; } wr_t;
  typedef struct { logic [7:0] b; int dl; } tx_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  uart_spram_bridge_if #(.ADDR_W(ADW)) bus ();
  uart_spram_bridge #(.ADDR_W(ADW), .RD_LAT(1), .TIMEOUT_CYC(TMO)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int busy_cnt = 0;
  int wren_cnt = 0;
  logic [15:0] spram   [0:M-1];
  logic [15:0] ref_mem [0:M-1];
  logic [15:0] wbuf    [0:255];
  wr_t  exp_wr[$];
  tx_t  exp_tx[$];
  logic [7:0] rx_log[$];
  logic prev_send = 1'b0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // SPRAM (1-cycle read) and uart transmitter models.
  always @(posedge clk) begin
    if (bus.ram_wren === 1'b1) begin
      spram[bus.ram_addr] <= bus.ram_wdata;
      wren_cnt <= wren_cnt + 1;
    end
    bus.ram_rdata <= spram[bus.ram_addr];
    if (bus.tx_send === 1'b1) busy_cnt <= BUSY_LEN;
    else if (busy_cnt > 0) busy_cnt <= busy_cnt - 1;
  end
  assign bus.tx_busy = (busy_cnt != 0);

  // Single compare process: every write and every transmitted byte.
  always @(negedge clk) begin
    wr_t ew;
    tx_t et;
    if (!rst) begin
      if (bus.ram_wren) begin
        if (exp_wr.size() == 0) check("unexpected_wren", 32'(bus.ram_addr), 32'hFFFF_FFFF);
        else begin
          ew = exp_wr.pop_front();
          check("wr_addr", 32'(bus.ram_addr), 32'(ew.addr));
          check("wr_data", 32'(bus.ram_wdata), 32'(ew.data));
          check("wr_cycle", 32'(cyc), 32'(ew.cyc));
        end
      end
      if (bus.tx_send) begin
        check("tx_handshake", {30'd0, bus.tx_busy, prev_send}, 32'd0);
        rx_log.push_back(bus.tx_data);
        if (exp_tx.size() == 0) check("unexpected_tx", 32'(bus.tx_data), 32'hFFFF_FFFF);
        else begin
          et = exp_tx.pop_front();
          check("tx_byte", 32'(bus.tx_data), 32'(et.b));
          if (et.dl > 0) check("tx_latency_ok", 32'(cyc <= et.dl), 32'd1);
        end
      end
      prev_send <= bus.tx_send;
    end
  end

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
  endtask

  task automatic send_byte_after(input logic [7:0] b, input int pre, output int c);
    repeat (pre) @(posedge clk);
    @(posedge clk); #1;
    bus.rx_valid = 1'b1;
    bus.rx_data  = b;
    c = cyc;
    @(posedge clk); #1;
    bus.rx_valid = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, output int c);
    send_byte_after(b, 2, c);
  endtask

  task automatic push_tx(input logic [7:0] b, input int dl);
    tx_t t;
    t.b = b; t.dl = dl;
    exp_tx.push_back(t);
  endtask

  task automatic push_wr(input int a, input logic [15:0] d, input int c);
    wr_t w;
    w.addr = a % M; w.data = d; w.cyc = c;
    exp_wr.push_back(w);
    ref_mem[a % M] = d;
  endtask

  task automatic send_hdr(input logic [7:0] cmd, input int a, input int n);
    int c;
    send_byte(cmd, c);
    send_byte(8'(a >> 8), c);
    send_byte(8'(a), c);
    send_byte(8'(n - 1), c);
  endtask

  task automatic frame_w(input int a, input int n);
    int c;
    send_hdr(8'h57, a, n);
    for (int k = 0; k < n; k++) begin
      send_byte(wbuf[k][15:8], c);
      send_byte(wbuf[k][7:0], c);
      push_wr(a + k, wbuf[k], c + 1);
    end
    push_tx(8'h06, c + 2);
  endtask

  task automatic frame_r(input int a, input int n);
    for (int k = 0; k < n; k++) begin
      push_tx(ref_mem[(a + k) % M][15:8], 0);
      push_tx(ref_mem[(a + k) % M][7:0], 0);
    end
    send_hdr(8'h52, a, n);
  endtask

  task automatic cmd_clr();
    int c;
    send_byte(8'h43, c);
    push_tx(8'h06, c + 2);
    idle(20);
    @(negedge clk);
    check("err_after_clr", 32'(bus.err), 32'd0);
  endtask

  initial begin
    int c, w0;
    bus.rx_valid = 1'b0;
    bus.rx_data  = 8'h00;
    idle(3);
    @(negedge clk);
    check("rst_wren", 32'(bus.ram_wren), 0);
    check("rst_tx_send", 32'(bus.tx_send), 0);
    check("rst_tx_data", 32'(bus.tx_data), 0);
    check("rst_addr", 32'(bus.ram_addr), 0);
    check("rst_wdata", 32'(bus.ram_wdata), 0);
    check("rst_busy", 32'(bus.busy), 0);
    check("rst_err", 32'(bus.err), 0);
    rst = 1'b0;
    idle(3);

    // Two-word write at 0x10
    wbuf[0] = 16'hAABB; wbuf[1] = 16'hCCDD;
    w0 = wren_cnt;
    frame_w(16'h0010, 2);
    idle(30);
    @(negedge clk);
    check("mem_10", 32'(spram[16'h10]), 32'hAABB);
    check("mem_11", 32'(spram[16'h11]), 32'hCCDD);
    check("w_wren_count", 32'(wren_cnt - w0), 32'd2);
    check("w_err", 32'(bus.err), 0);
    check("w_busy", 32'(bus.busy), 0);

    // Read it back: literal byte order
    rx_log.delete();
    frame_r(16'h0010, 2);
    idle(60);
    @(negedge clk);
    check("r_len", 32'(rx_log.size()), 32'd4);
    check("r_b0", 32'(rx_log[0]), 32'hAA);
    check("r_b1", 32'(rx_log[1]), 32'hBB);
    check("r_b2", 32'(rx_log[2]), 32'hCC);
    check("r_b3", 32'(rx_log[3]), 32'hDD);
    check("r_busy", 32'(bus.busy), 0);

    // Burst across the top of the address space
    wbuf[0] = 16'h1234; wbuf[1] = 16'h5678;
    frame_w(16'h3FFF, 2);
    idle(30);
    @(negedge clk);
    check("mem_3fff", 32'(spram[16'h3FFF]), 32'h1234);
    check("mem_0000", 32'(spram[0]), 32'h5678);
    frame_r(16'h3FFF, 2);
    idle(60);

    // Low byte arriving exactly on the expiry cycle is accepted
    send_hdr(8'h57, 16'h0040, 1);
    send_byte(8'h9A, c);
    send_byte_after(8'hBC, TMO - 2, c);
    push_wr(16'h0040, 16'h9ABC, c + 1);
    push_tx(8'h06, c + 2);
    idle(30);
    @(negedge clk);
    check("late_byte_err", 32'(bus.err), 0);
    check("mem_40", 32'(spram[16'h40]), 32'h9ABC);

    // Timeout after one data byte
    w0 = wren_cnt;
    send_hdr(8'h57, 16'h0000, 1);
    send_byte(8'h12, c);
    push_tx(8'h15, c + TMO + 1);
    repeat (TMO) @(negedge clk);
    check("tmo_err_before", 32'(bus.err), 0);
    check("tmo_busy_before", 32'(bus.busy), 1);
    @(negedge clk);
    check("tmo_err", 32'(bus.err), 1);
    check("tmo_busy", 32'(bus.busy), 0);
    idle(20);
    check("tmo_no_wren", 32'(wren_cnt - w0), 0);
    cmd_clr();

    // Unknown command
    send_byte(8'h58, c);
    push_tx(8'h15, c + 1);
    @(negedge clk);
    check("nak_err", 32'(bus.err), 1);
    check("nak_busy", 32'(bus.busy), 0);
    idle(20);
    cmd_clr();

    // Overrun during a read reply
    rx_log.delete();
    frame_r(16'h0010, 2);
    send_byte(8'h00, c);
    idle(60);
    @(negedge clk);
    check("ovr_err", 32'(bus.err), 1);
    check("ovr_len", 32'(rx_log.size()), 32'd4);
    check("ovr_busy", 32'(bus.busy), 0);

    // Reset in the middle of a write frame
    w0 = wren_cnt;
    send_hdr(8'h57, 16'h0020, 1);
    send_byte(8'h55, c);
    #2;
    rst = 1'b1;
    #1;
    check("mid_rst_wren", 32'(bus.ram_wren), 0);
    check("mid_rst_busy", 32'(bus.busy), 0);
    check("mid_rst_err", 32'(bus.err), 0);
    check("mid_rst_addr", 32'(bus.ram_addr), 0);
    check("mid_rst_wdata", 32'(bus.ram_wdata), 0);
    check("mid_rst_tx_data", 32'(bus.tx_data), 0);
    idle(3);
    #1;
    rst = 1'b0;
    idle(20);
    check("mid_rst_no_wren", 32'(wren_cnt - w0), 0);
    wbuf[0] = 16'h6677;
    frame_w(16'h0020, 1);
    idle(30);
    rx_log.delete();
    frame_r(16'h0020, 1);
    idle(40);
    @(negedge clk);
    check("post_rst_len", 32'(rx_log.size()), 32'd2);
    check("post_rst_b0", 32'(rx_log[0]), 32'h66);
    check("post_rst_b1", 32'(rx_log[1]), 32'h77);

    check("exp_wr_drained", 32'(exp_wr.size()), 0);
    check("exp_tx_drained", 32'(exp_tx.size()), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
